regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between several writeback requesters (ALU, load unit, multiplier/CSR) using round-robin arbitration with a valid/ready handshake. It registers the winning write for one cycle before driving the register file's write/Daddress/Ddata inputs. It also keeps a per-register busy scoreboard: the issue stage reserves destinations, and the scoreboard reports hazards on the two read addresses. It sits between the execute/memory units and the register file.

---
 rtl/regfile_write_arbiter_if.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the requesters/issue stage and the register-file write arbiter.
// Carries the request handshake, the registered write port and the busy scoreboard queries.
interface regfile_write_arbiter_if #(
  parameter int REQUESTERS = 3
);
  logic [REQUESTERS-1:0]    req_valid;
  logic [5*REQUESTERS-1:0]  req_addr;
  logic [32*REQUESTERS-1:0] req_data;
  logic [REQUESTERS-1:0]    req_ready;
  logic                     rf_write;
  logic [4:0]               rf_addr;
  logic [31:0]              rf_data;
  logic [1:0]               rf_grant_id;
  logic                     reserve_valid;
  logic [4:0]               reserve_addr;
  logic [4:0]               a_addr;
  logic [4:0]               b_addr;
  logic                     a_busy;
  logic                     b_busy;

  modport master (
    output req_valid, req_addr, req_data, reserve_valid, reserve_addr, a_addr, b_addr,
    input  req_ready, rf_write, rf_addr, rf_data, rf_grant_id, a_busy, b_busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, reserve_valid, reserve_addr, a_addr, b_addr,
    output req_ready, rf_write, rf_addr, rf_data, rf_grant_id, a_busy, b_busy
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a registered
// write stage and a per-register busy scoreboard for read-operand hazard detection.
module regfile_write_arbiter #(
  parameter int REQUESTERS = 3
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  regfile_write_arbiter_if.slave io_wb
);

  localparam logic [2:0] NREQ = 3'(REQUESTERS);

  logic [1:0]   r_ptr;
  logic         r_rf_write;
  logic [4:0]   r_rf_addr;
  logic [31:0]  r_rf_data;
  logic [1:0]   r_rf_grant_id;
  logic [31:0]  r_busy;

  logic [3:0]   w_valid4;
  logic [3:0]   w_ready4;
  logic [19:0]  w_addr_all;
  logic [127:0] w_data_all;
  logic         w_found;
  logic [1:0]   w_winner;
  logic [2:0]   w_idx;
  logic [4:0]   w_addr;
  logic [31:0]  w_data;
  logic [1:0]   w_ptr_nxt;
  logic [31:0]  w_set;
  logic [31:0]  w_clr;
  logic [31:0]  w_busy_nxt;

  // Zero-extend to the 4-requester maximum so indexing stays in range for any legal size.
  assign w_valid4   = 4'(io_wb.req_valid);
  assign w_addr_all = 20'(io_wb.req_addr);
  assign w_data_all = 128'(io_wb.req_data);

  always_comb begin
    w_found  = 1'b0;
    w_winner = 2'd0;
    w_idx    = 3'd0;
    for (int k = 0; k < REQUESTERS; k++) begin
      w_idx = {1'b0, r_ptr} + 3'(k);
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && w_valid4[w_idx[1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[1:0];
      end
    end
  end

  always_comb begin
    w_ready4 = 4'd0;
    w_addr   = 5'd0;
    w_data   = 32'd0;
    if (w_found && i_rst_n) w_ready4[w_winner] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_winner == 2'(i)) begin
        w_addr = w_addr_all[i*5 +: 5];
        w_data = w_data_all[i*32 +: 32];
      end
    end
  end

  assign w_ptr_nxt = ({1'b0, w_winner} == NREQ - 3'd1) ? 2'd0 : w_winner + 2'd1;

  // Set is applied after clear: a reservation on the retiring register is younger and wins.
  assign w_clr      = r_rf_write ? (32'd1 << r_rf_addr) : 32'd0;
  assign w_set      = io_wb.reserve_valid ? (32'd1 << io_wb.reserve_addr) : 32'd0;
  assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & 32'hFFFF_FFFE;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr         <= 2'd0;
      r_rf_write    <= 1'b0;
      r_rf_addr     <= 5'd0;
      r_rf_data     <= 32'd0;
      r_rf_grant_id <= 2'd0;
      r_busy        <= 32'd0;
    end else begin
      if (w_found) begin
        r_ptr         <= w_ptr_nxt;
        r_rf_addr     <= w_addr;
        r_rf_data     <= w_data;
        r_rf_grant_id <= w_winner;
      end
      r_rf_write <= w_found && (w_addr != 5'd0);
      r_busy     <= w_busy_nxt;
    end
  end

  assign io_wb.req_ready   = w_ready4[REQUESTERS-1:0];
  assign io_wb.rf_write    = r_rf_write;
  assign io_wb.rf_addr     = r_rf_addr;
  assign io_wb.rf_data     = r_rf_data;
  assign io_wb.rf_grant_id = r_rf_grant_id;
  assign io_wb.a_busy      = r_busy[io_wb.a_addr];
  assign io_wb.b_busy      = r_busy[io_wb.b_addr];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin / scoreboard model.
module tb_regfile_write_arbiter;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.REQUESTERS(R)) u_if ();
  regfile_write_arbiter #(.REQUESTERS(R)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_wb  (u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // staged stimulus
  logic [R-1:0] s_valid;
  logic [4:0]   s_addr[R];
  logic [31:0]  s_data[R];
  logic         s_rv;
  logic [4:0]   s_raddr;
  logic [4:0]   s_a;
  logic [4:0]   s_b;

  // reference model
  int          m_ptr;
  bit          m_busy[32];
  bit          m_write;
  int          m_addr;
  logic [31:0] m_data;
  int          m_gid;

  function automatic int m_winner();
    for (int k = 0; k < R; k++) begin
      if (s_valid[(m_ptr + k) % R]) return (m_ptr + k) % R;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_write = 0; m_addr = 0; m_data = 0; m_gid = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
  endtask

  task automatic clear_stage();
    s_valid = '0; s_rv = 0; s_raddr = 0; s_a = 0; s_b = 0;
    for (int i = 0; i < R; i++) begin s_addr[i] = 0; s_data[i] = 0; end
  endtask

  task automatic randomize_stage();
    s_valid = R'($urandom);
    for (int i = 0; i < R; i++) begin
      s_addr[i] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      s_data[i] = $urandom;
    end
    s_rv    = ($urandom_range(0, 9) < 3);
    s_raddr = 5'($urandom_range(0, 7));
    s_a     = 5'($urandom_range(0, 7));
    s_b     = 5'($urandom);
  endtask

  task automatic apply();
    u_if.req_valid = s_valid;
    for (int i = 0; i < R; i++) begin
      u_if.req_addr[i*5 +: 5]  = s_addr[i];
      u_if.req_data[i*32 +: 32] = s_data[i];
    end
    u_if.reserve_valid = s_rv;
    u_if.reserve_addr  = s_raddr;
    u_if.a_addr        = s_a;
    u_if.b_addr        = s_b;
  endtask

  task automatic tick();
    int w;
    logic [31:0] exp_ready;
    @(negedge clk);
    apply();
    #1;
    w = m_winner();
    exp_ready = (w >= 0) ? (32'd1 << w) : 32'd0;
    chk("req_ready", 32'(u_if.req_ready), exp_ready);
    chk("a_busy", 32'(u_if.a_busy), 32'(m_busy[s_a]));
    chk("b_busy", 32'(u_if.b_busy), 32'(m_busy[s_b]));
    @(posedge clk);
    if (m_write) m_busy[m_addr] = 0;
    if (s_rv && s_raddr != 0) m_busy[s_raddr] = 1;
    if (w >= 0) begin
      m_ptr   = (w + 1) % R;
      m_write = (s_addr[w] != 0);
      m_addr  = s_addr[w];
      m_data  = s_data[w];
      m_gid   = w;
    end else begin
      m_write = 0;
    end
    #1;
    chk("rf_write", 32'(u_if.rf_write), 32'(m_write));
    chk("rf_addr", 32'(u_if.rf_addr), 32'(m_addr));
    chk("rf_data", u_if.rf_data, m_data);
    chk("rf_grant_id", 32'(u_if.rf_grant_id), 32'(m_gid));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(u_if.req_ready), 32'd0);
    chk({tag, "_write"}, 32'(u_if.rf_write), 32'd0);
    chk({tag, "_addr"}, 32'(u_if.rf_addr), 32'd0);
    chk({tag, "_data"}, u_if.rf_data, 32'd0);
    chk({tag, "_gid"}, 32'(u_if.rf_grant_id), 32'd0);
    chk({tag, "_abusy"}, 32'(u_if.a_busy), 32'd0);
  endtask

  initial begin
    model_reset();
    clear_stage();
    apply();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // all three requesters valid: grants 0,1,2,0,1,2 back to back
    s_valid = 3'b111;
    for (int i = 0; i < R; i++) begin s_addr[i] = 5'(10 + i); s_data[i] = 32'h100 + 32'(i); end
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_gid", 32'(u_if.rf_grant_id), 32'(k % 3));
      chk("rr_write", 32'(u_if.rf_write), 32'd1);
    end
    clear_stage();
    tick();

    // single requester 1
    s_valid = 3'b010; s_addr[1] = 5'd5; s_data[1] = 32'hDEADBEEF;
    tick();
    chk("single_write", 32'(u_if.rf_write), 32'd1);
    chk("single_addr", 32'(u_if.rf_addr), 32'd5);
    chk("single_data", u_if.rf_data, 32'hDEADBEEF);
    chk("single_gid", 32'(u_if.rf_grant_id), 32'd1);
    clear_stage();
    tick();
    chk("single_idle_write", 32'(u_if.rf_write), 32'd0);
    chk("single_idle_addr", 32'(u_if.rf_addr), 32'd5);

    // requester 2 writes x0: handshake, pointer advances to 0, no write
    s_valid = 3'b100; s_addr[2] = 5'd0; s_a = 5'd0;
    tick();
    chk("x0_write", 32'(u_if.rf_write), 32'd0);
    chk("x0_abusy", 32'(u_if.a_busy), 32'd0);
    clear_stage();
    s_valid = 3'b111;
    for (int i = 0; i < R; i++) s_addr[i] = 5'(20 + i);
    tick();
    chk("x0_next_gid", 32'(u_if.rf_grant_id), 32'd0);
    clear_stage();
    tick();

    // reserve x7, then retire it via requester 0
    s_rv = 1; s_raddr = 5'd7; s_a = 5'd7;
    tick();
    chk("x7_reserved", 32'(u_if.a_busy), 32'd1);
    s_rv = 0; s_valid = 3'b001; s_addr[0] = 5'd7; s_data[0] = 32'h7777;
    tick();
    chk("x7_wr", 32'(u_if.rf_write), 32'd1);
    chk("x7_busy_during_wr", 32'(u_if.a_busy), 32'd1);
    s_valid = '0;
    tick();
    chk("x7_cleared", 32'(u_if.a_busy), 32'd0);

    // set wins over clear on x9
    clear_stage();
    s_rv = 1; s_raddr = 5'd9; s_a = 5'd9;
    tick();
    s_rv = 0; s_valid = 3'b001; s_addr[0] = 5'd9;
    tick();
    s_valid = '0; s_rv = 1; s_raddr = 5'd9;
    tick();
    chk("x9_set_wins", 32'(u_if.a_busy), 32'd1);
    s_rv = 0;
    tick();
    chk("x9_still_busy", 32'(u_if.a_busy), 32'd1);

    // randomized traffic with an asynchronous reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        @(negedge clk);
        randomize_stage();
        apply();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        chk("midrst_hold_ready", 32'(u_if.req_ready), 32'd0);
        chk("midrst_hold_write", 32'(u_if.rf_write), 32'd0);
        @(negedge clk);
        clear_stage();
        apply();
        rst_n = 1'b1;
      end
      randomize_stage();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
